// File: rtl/clock_pkg.sv
// Shared constants, state encodings and the BCD helper for the watch's serial time reporter.
package clock_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         MSG_LEN     = 10;

    // Line-level view: the byte serializer owns START..STOP, the sequencer owns IDLE/SNAP.
    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SNAP,
        SEQ_SEND
    } seq_t;

    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
        logic [6:0] sat;
        sat = (bin > 7'd99) ? 7'd99 : bin;
        return {4'(sat / 7'd10), 4'(sat % 7'd10)};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer (start, 8 data bits LSB first, optional even parity, stop).
// Back-to-back bytes: a byte offered during the last stop-bit cycle starts with no idle gap.
module uart_tx_byte
    import clock_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output state_t     o_state
);

    localparam int             BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  LAST_CNT = BW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;
    logic          w_bit_end;
    logic          w_fire;

    // Handshake: a byte transfers on a clock edge where i_valid and o_ready are both high;
    // i_data must be stable while i_valid is high, and o_ready never depends on i_valid.
    assign w_bit_end = (r_baud == LAST_CNT);
    assign o_ready   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign w_fire    = i_valid && o_ready;
    assign o_state   = r_state;

    always_comb begin
        w_next = r_state;
        o_tx   = 1'b1;
        case (r_state)
            IDLE: begin
                if (i_valid) w_next = START;
            end
            START: begin
                o_tx = 1'b0;
                if (w_bit_end) w_next = DATA;
            end
            DATA: begin
                o_tx = r_data[r_bit];
                if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef TIME_UART_TX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef TIME_UART_TX_PARITY_EN
            PARITY: begin
                o_tx = ^r_data;
                if (w_bit_end) w_next = STOP;
            end
`endif
            STOP: begin
                if (w_bit_end) w_next = i_valid ? START : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) || w_bit_end) r_baud <= '0;
            else                                r_baud <= r_baud + 1'b1;
            // 3-bit counter wraps back to 0 after bit 7, ready for the next byte.
            if ((r_state == DATA) && w_bit_end) r_bit <= r_bit + 1'b1;
            if (w_fire) r_data <= i_data;
        end
    end

endmodule

// File: rtl/time_uart_tx.sv
// Sends "HH:MM:SS\r\n" on each accepted one-second tick; TIME_UART_TX_PARITY_EN selects 8E1
// instead of 8N1. Ticks arriving while a line is in flight are dropped and flagged on drop_o.
module time_uart_tx
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       seconds_pulse_i,
    input  logic       enable_i,
    input  logic [6:0] seconds_i,
    input  logic [5:0] minutes_i,
    input  logic [4:0] hours_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       drop_o,
    output state_t     dbg_state_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    seq_t       r_seq;
    seq_t       w_seq_next;
    logic [3:0] r_idx;
    logic [4:0] r_hours;
    logic [5:0] r_minutes;
    logic [6:0] r_seconds;
    logic [4:0] w_hours;
    logic [5:0] w_minutes;
    logic [6:0] w_seconds;
    logic [7:0] w_h_bcd;
    logic [7:0] w_m_bcd;
    logic [7:0] w_s_bcd;
    logic [7:0] w_byte;
    logic       w_tick;
    logic       w_valid;
    logic       w_ready;
    state_t     w_byte_state;

    assign w_tick = seconds_pulse_i && enable_i;
    assign busy_o = (r_seq != SEQ_IDLE);
    assign drop_o = w_tick && busy_o;

    // Byte 0 leaves during SNAP, before the snapshot registers load, so SNAP reads the live inputs.
    assign w_hours   = (r_seq == SEQ_SNAP) ? hours_i   : r_hours;
    assign w_minutes = (r_seq == SEQ_SNAP) ? minutes_i : r_minutes;
    assign w_seconds = (r_seq == SEQ_SNAP) ? seconds_i : r_seconds;

    assign w_h_bcd = bin_to_bcd2({2'b00, w_hours});
    assign w_m_bcd = bin_to_bcd2({1'b0, w_minutes});
    assign w_s_bcd = bin_to_bcd2(w_seconds);

    always_comb begin
        w_byte = ASCII_LF;
        case (r_idx)
            4'd0:    w_byte = ASCII_ZERO + {4'h0, w_h_bcd[7:4]};
            4'd1:    w_byte = ASCII_ZERO + {4'h0, w_h_bcd[3:0]};
            4'd2:    w_byte = ASCII_COLON;
            4'd3:    w_byte = ASCII_ZERO + {4'h0, w_m_bcd[7:4]};
            4'd4:    w_byte = ASCII_ZERO + {4'h0, w_m_bcd[3:0]};
            4'd5:    w_byte = ASCII_COLON;
            4'd6:    w_byte = ASCII_ZERO + {4'h0, w_s_bcd[7:4]};
            4'd7:    w_byte = ASCII_ZERO + {4'h0, w_s_bcd[3:0]};
            4'd8:    w_byte = ASCII_CR;
            default: w_byte = ASCII_LF;
        endcase
    end

    always_comb begin
        w_seq_next = r_seq;
        w_valid    = 1'b0;
        case (r_seq)
            SEQ_IDLE: begin
                if (w_tick) w_seq_next = SEQ_SNAP;
            end
            SEQ_SNAP: begin
                w_valid = 1'b1;
                if (w_ready) w_seq_next = SEQ_SEND;
            end
            SEQ_SEND: begin
                w_valid = (r_idx < 4'(MSG_LEN));
                // With all bytes handed off, ready in STOP marks the end of the final stop bit.
                if (!w_valid && w_ready) w_seq_next = SEQ_IDLE;
            end
            default: w_seq_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_seq     <= SEQ_IDLE;
            r_idx     <= '0;
            r_hours   <= '0;
            r_minutes <= '0;
            r_seconds <= '0;
        end else begin
            r_seq <= w_seq_next;
            if (r_seq == SEQ_IDLE)       r_idx <= '0;
            else if (w_valid && w_ready) r_idx <= r_idx + 1'b1;
            if (r_seq == SEQ_SNAP) begin
                r_hours   <= hours_i;
                r_minutes <= minutes_i;
                r_seconds <= seconds_i;
            end
        end
    end

    always_comb begin
        case (r_seq)
            SEQ_IDLE: dbg_state_o = IDLE;
            SEQ_SNAP: dbg_state_o = SNAP;
            default:  dbg_state_o = w_byte_state;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .i_clk  (clk_i),
        .i_rstn (rstn_i),
        .i_valid(w_valid),
        .i_data (w_byte),
        .o_ready(w_ready),
        .o_tx   (tx_o),
        .o_state(w_byte_state)
    );

endmodule

// File: tb/tb_time_uart_tx.sv
// Bench for time_uart_tx at 10 clocks per bit; lines are decoded at fixed bit centres and
// compared with text formatted from the applied time. Build with TIME_UART_TX_PARITY_EN for 8E1.
module tb_time_uart_tx;
    import clock_pkg::*;

    localparam int CPB = 10;
`ifdef TIME_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BYTE_CYC  = FRAME_BITS * CPB;
    localparam int LINE_BUSY = 1 + MSG_LEN * BYTE_CYC;

    logic       clk = 1'b0;
    logic       rstn_i;
    logic       seconds_pulse_i;
    logic       enable_i;
    logic [6:0] seconds_i;
    logic [5:0] minutes_i;
    logic [4:0] hours_i;
    logic       tx_o;
    logic       busy_o;
    logic       drop_o;
    state_t     dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int busy_run = 0;
    int last_busy_len = 0;
    int drop_cyc = 0;

    logic [7:0] exp_q[$];

    time_uart_tx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .seconds_pulse_i(seconds_pulse_i),
        .enable_i       (enable_i),
        .seconds_i      (seconds_i),
        .minutes_i      (minutes_i),
        .hours_i        (hours_i),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .drop_o         (drop_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Busy-length and drop-pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (drop_o === 1'b1) drop_cyc++;
        if (busy_o === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    // ---------------- scoreboard / model ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic push_line(input int h, input int m, input int s);
        string str;
        str = $sformatf("%02d:%02d:%02d\r\n", sat99(h), sat99(m), sat99(s));
        for (int i = 0; i < str.len(); i++) exp_q.push_back(str[i]);
    endtask

    // ---------------- drivers ----------------
    task automatic set_time(input int h, input int m, input int s);
        hours_i   = 5'(h);
        minutes_i = 6'(m);
        seconds_i = 7'(s);
    endtask

    task automatic tick();
        @(negedge clk);
        seconds_pulse_i = 1'b1;
        @(negedge clk);
        seconds_pulse_i = 1'b0;
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        check({tag, "_line_quiet"}, 32'(lows), 32'd0);
        check({tag, "_not_busy"}, 32'(busy_o), 32'd0);
    endtask

    // Decodes one full line at bit centres: any change of bit length shifts later samples.
    task automatic rx_line(input string tag);
        int t;
        int pos;
        int target;
        logic [7:0] b;
        logic [7:0] e;
        t = 0;
        @(negedge clk);
        while (tx_o !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start_seen"}, 32'(t < 40), 32'd1);
        if (t >= 40) begin
            for (int k = 0; k < MSG_LEN; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        pos = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            e = exp_q.pop_front();
            b = '0;
            for (int j = 0; j < FRAME_BITS; j++) begin
                target = k * BYTE_CYC + j * CPB + CPB / 2 - 1;
                repeat (target - pos) @(negedge clk);
                pos = target;
                if (j == 0)
                    check($sformatf("%s_b%0d_start", tag, k), 32'(tx_o), 32'd0);
                else if (j <= 8)
                    b[j-1] = tx_o;
                else if (j == FRAME_BITS - 1)
                    check($sformatf("%s_b%0d_stop", tag, k), 32'(tx_o), 32'd1);
                else
                    check($sformatf("%s_b%0d_parity", tag, k), 32'(tx_o), 32'(^e));
            end
            check($sformatf("%s_b%0d_byte", tag, k), 32'(b), 32'(e));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int h;
        int m;
        int s;
        int d0;
        int t;

        rstn_i          = 1'b0;
        seconds_pulse_i = 1'b0;
        enable_i        = 1'b1;
        set_time(13, 7, 42);

        // Reset held: outputs quiet even with ticks arriving.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seconds_pulse_i = 1'($urandom_range(0, 1));
            #1;
            check("rst_tx", 32'(tx_o), 32'd1);
            check("rst_busy", 32'(busy_o), 32'd0);
            check("rst_drop", 32'(drop_o), 32'd0);
        end
        check("rst_state", 32'(dbg_state_o), 32'(IDLE));
        seconds_pulse_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        quiet_window("post_rst", 20);

        // Basic line and busy length.
        set_time(13, 7, 42);
        push_line(13, 7, 42);
        tick();
        check("snap_busy", 32'(busy_o), 32'd1);
        check("snap_state", 32'(dbg_state_o), 32'(SNAP));
        rx_line("basic");
        repeat (20) @(negedge clk);
        check("basic_busy_len", 32'(last_busy_len), 32'(LINE_BUSY));
        check("basic_idle_tx", 32'(tx_o), 32'd1);

        // Counter rolls over on the tick cycle; the line shows the updated value.
        @(negedge clk);
        set_time(0, 0, 59);
        seconds_pulse_i = 1'b1;
        @(negedge clk);
        seconds_pulse_i = 1'b0;
        set_time(0, 1, 0);
        push_line(0, 1, 0);
        fork
            rx_line("snapshot");
            begin
                repeat (30) @(negedge clk);
                set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            end
        join
        repeat (20) @(negedge clk);

        // Tick while busy is dropped and not queued.
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        set_time(h, m, s);
        push_line(h, m, s);
        d0 = drop_cyc;
        tick();
        fork
            rx_line("busy_tick");
            begin
                repeat (300) @(negedge clk);
                tick();
            end
        join
        check("busy_tick_drop_cycles", 32'(drop_cyc - d0), 32'd1);
        quiet_window("busy_tick", 150);

        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        set_time(h, m, s);
        push_line(h, m, s);
        tick();
        rx_line("after_drop");
        repeat (20) @(negedge clk);

        // Tick on the final stop-bit cycle is still a busy tick.
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        set_time(h, m, s);
        push_line(h, m, s);
        d0 = drop_cyc;
        tick();
        fork
            rx_line("last_stop");
            begin
                repeat (LINE_BUSY - 1) @(negedge clk);
                seconds_pulse_i = 1'b1;
                @(negedge clk);
                seconds_pulse_i = 1'b0;
            end
        join
        check("last_stop_drop_cycles", 32'(drop_cyc - d0), 32'd1);
        quiet_window("last_stop", 150);

        // Disabled ticks are ignored without a drop.
        enable_i = 1'b0;
        d0 = drop_cyc;
        tick();
        quiet_window("disabled", 50);
        check("disabled_no_drop", 32'(drop_cyc - d0), 32'd0);
        enable_i = 1'b1;

        // Enable falling mid-frame does not cut the line short.
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        set_time(h, m, s);
        push_line(h, m, s);
        tick();
        fork
            rx_line("enable_fall");
            begin
                repeat (200) @(negedge clk);
                enable_i = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("enable_fall_busy_len", 32'(last_busy_len), 32'(LINE_BUSY));
        enable_i = 1'b1;

        // Random times, then out-of-range values that saturate to 99.
        for (int i = 0; i < 3; i++) begin
            h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
            set_time(h, m, s);
            push_line(h, m, s);
            tick();
            rx_line($sformatf("rand%0d", i));
            repeat (20) @(negedge clk);
        end
        set_time(23, 59, 120);
        push_line(23, 59, 120);
        tick();
        rx_line("sat120");
        repeat (20) @(negedge clk);
        h = $urandom_range(24, 31); m = $urandom_range(60, 63); s = $urandom_range(100, 127);
        set_time(h, m, s);
        push_line(h, m, s);
        tick();
        rx_line("sat_rand");
        repeat (20) @(negedge clk);

        // Reset during byte 4 (a '7'), data bit 3 which is low on the line.
        set_time(13, 7, 42);
        tick();
        t = 0;
        @(negedge clk);
        while (tx_o !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("midrst_start_seen", 32'(t < 40), 32'd1);
        repeat (4 * BYTE_CYC + 4 * CPB + CPB / 2 - 1) @(negedge clk);
        check("midrst_bit_low", 32'(tx_o), 32'd0);
        #2;
        rstn_i = 1'b0;
        #1;
        check("midrst_tx_high", 32'(tx_o), 32'd1);
        check("midrst_busy_low", 32'(busy_o), 32'd0);
        check("midrst_state", 32'(dbg_state_o), 32'(IDLE));
        @(negedge clk);
        rstn_i = 1'b1;
        quiet_window("midrst_release", 30);

        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        set_time(h, m, s);
        push_line(h, m, s);
        tick();
        rx_line("after_rst");
        repeat (20) @(negedge clk);
        check("after_rst_busy_len", 32'(last_busy_len), 32'(LINE_BUSY));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
